// File: rtl/lc3_isdu_ctrl_pkg.sv
// lc3_isdu_ctrl_pkg: shared types and encodings for the SLC-3 sequencing/decode unit.
//   state_e   : controller state encoding, also exported on State_Dbg
//   ctrl_t    : packed control word driven to the datapath
//   OP_*      : opcodes decoded from IR[15:12]
//   PCMUX_*, ADDR2_*, ALUK_* : mux/ALU select encodings
package lc3_isdu_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_HALTED, ST_FETCH1, ST_FETCH2, ST_FETCH3, ST_DECODE,
        ST_BR_TEST, ST_BR_TAKE, ST_ALU,
        ST_LDR_A, ST_LDR_M, ST_LDR_W,
        ST_STR_A, ST_STR_D, ST_STR_M,
        ST_JMP, ST_JSR_A, ST_JSR_B,
        ST_PAUSE, ST_PAUSE2
    } state_e;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    // sr1mux: 0 selects IR[11:9], 1 selects IR[8:6]; drmux: 0 IR[11:9], 1 R7;
    // addr1mux: 0 PC, 1 SR1 (BaseR); mio_en: 1 MDR loads from memory.
    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_led;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       mem_oe;
        logic       mem_we;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [1:0] alu_op(input logic [3:0] op);
        return op == OP_AND ? ALUK_AND : op == OP_NOT ? ALUK_NOT : ALUK_ADD;
    endfunction

endpackage

// File: rtl/lc3_isdu_ctrl_if.sv
// lc3_isdu_ctrl_if: bundle between the top level/datapath (master) and the sequencer (slave).
//   Run, Continue, IR, BEN : into the sequencer
//   Ctrl, State_Dbg        : out of the sequencer
interface lc3_isdu_ctrl_if;
    import lc3_isdu_ctrl_pkg::*;

    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;
    ctrl_t       Ctrl;
    logic [4:0]  State_Dbg;

    modport master (output Run, Continue, IR, BEN, input Ctrl, State_Dbg);
    modport slave  (input Run, Continue, IR, BEN, output Ctrl, State_Dbg);

endinterface

// File: rtl/lc3_isdu_ctrl_mem_wait_timer.sv
// lc3_isdu_ctrl_mem_wait_timer: counts the cycles of one memory access.
//   Clk, Reset : clock and synchronous active-high reset
//   start      : held high for the whole access (while in a memory state)
//   last       : high in the final (MEM_WAIT-th) cycle of the access
module lc3_isdu_ctrl_mem_wait_timer #(
    parameter int MEM_WAIT = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    output logic last
);
    localparam int W = $clog2(MEM_WAIT + 1);

    logic [W-1:0] cnt;

    assign last = start && cnt == W'(MEM_WAIT - 1);

    // Clearing on last leaves the counter at zero for the next access.
    always_ff @(posedge Clk)
        cnt <= (Reset || !start || last) ? '0 : cnt + W'(1);

endmodule

// File: rtl/lc3_isdu_ctrl.sv
// lc3_isdu_ctrl: Moore FSM sequencing fetch/decode/execute for the SLC-3 datapath.
//   Clk, Reset : clock and synchronous active-high reset
//   bus        : Run/Continue/IR/BEN in, Ctrl word and State_Dbg out
module lc3_isdu_ctrl
    import lc3_isdu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 3
) (
    input logic            Clk,
    input logic            Reset,
    lc3_isdu_ctrl_if.slave bus
);
    state_e     state, state_nxt;
    ctrl_t      c;
    logic       mem_act, mem_last;
    logic [3:0] op;

    assign op            = bus.IR[15:12];
    assign mem_act       = state inside {ST_FETCH2, ST_LDR_M, ST_STR_M};
    assign bus.Ctrl      = c;
    assign bus.State_Dbg = state;

    lc3_isdu_ctrl_mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .start (mem_act),
        .last  (mem_last)
    );

    always_ff @(posedge Clk)
        state <= Reset ? ST_HALTED : state_nxt;

    always_comb begin
        state_nxt = state;
        c = CTRL_IDLE;
        case (state)
            ST_HALTED: if (bus.Run) state_nxt = ST_FETCH1;
            ST_FETCH1: begin
                c.gate_pc = 1'b1;
                c.ld_mar  = 1'b1;
                c.pcmux   = PCMUX_INC;
                c.ld_pc   = 1'b1;
                state_nxt = ST_FETCH2;
            end
            ST_FETCH2, ST_LDR_M: begin
                c.mem_oe = 1'b1;
                c.mio_en = 1'b1;
                c.ld_mdr = mem_last;
                if (mem_last) state_nxt = state == ST_FETCH2 ? ST_FETCH3 : ST_LDR_W;
            end
            ST_FETCH3: begin
                c.gate_mdr = 1'b1;
                c.ld_ir    = 1'b1;
                state_nxt  = ST_DECODE;
            end
            ST_DECODE: begin
                c.ld_ben = 1'b1;
                case (op)
                    OP_BR:                  state_nxt = ST_BR_TEST;
                    OP_ADD, OP_AND, OP_NOT: state_nxt = ST_ALU;
                    OP_LDR:                 state_nxt = ST_LDR_A;
                    OP_STR:                 state_nxt = ST_STR_A;
                    OP_JMP:                 state_nxt = ST_JMP;
                    OP_JSR:                 state_nxt = ST_JSR_A;
                    OP_PAUSE:               state_nxt = ST_PAUSE;
                    default:                state_nxt = ST_FETCH1;
                endcase
            end
            ST_BR_TEST: state_nxt = bus.BEN ? ST_BR_TAKE : ST_FETCH1;
            ST_BR_TAKE: begin
                c.addr2mux = ADDR2_OFF9;
                c.pcmux    = PCMUX_ADDER;
                c.ld_pc    = 1'b1;
                state_nxt  = ST_FETCH1;
            end
            ST_ALU: begin
                c.aluk     = alu_op(op);
                c.sr1mux   = 1'b1;
                c.sr2mux   = bus.IR[5];
                c.gate_alu = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                state_nxt  = ST_FETCH1;
            end
            ST_LDR_A, ST_STR_A: begin
                c.addr1mux    = 1'b1;
                c.sr1mux      = 1'b1;
                c.addr2mux    = ADDR2_OFF6;
                c.gate_marmux = 1'b1;
                c.ld_mar      = 1'b1;
                state_nxt     = state == ST_LDR_A ? ST_LDR_M : ST_STR_D;
            end
            ST_LDR_W: begin
                c.gate_mdr = 1'b1;
                c.ld_reg   = 1'b1;
                c.ld_cc    = 1'b1;
                state_nxt  = ST_FETCH1;
            end
            // Source register IR[11:9] passes through the ALU into MDR.
            ST_STR_D: begin
                c.aluk     = ALUK_PASS;
                c.gate_alu = 1'b1;
                c.ld_mdr   = 1'b1;
                state_nxt  = ST_STR_M;
            end
            ST_STR_M: begin
                c.mem_we = 1'b1;
                if (mem_last) state_nxt = ST_FETCH1;
            end
            ST_JMP: begin
                c.addr1mux = 1'b1;
                c.sr1mux   = 1'b1;
                c.addr2mux = ADDR2_ZERO;
                c.pcmux    = PCMUX_ADDER;
                c.ld_pc    = 1'b1;
                state_nxt  = ST_FETCH1;
            end
            ST_JSR_A: begin
                c.gate_pc = 1'b1;
                c.drmux   = 1'b1;
                c.ld_reg  = 1'b1;
                state_nxt = ST_JSR_B;
            end
            // IR[11]=1: PC+off11; otherwise BaseR+0 through the address adder.
            ST_JSR_B: begin
                c.addr1mux = !bus.IR[11];
                c.sr1mux   = !bus.IR[11];
                c.addr2mux = bus.IR[11] ? ADDR2_OFF11 : ADDR2_ZERO;
                c.pcmux    = PCMUX_ADDER;
                c.ld_pc    = 1'b1;
                state_nxt  = ST_FETCH1;
            end
            // Two states so a Continue already high on entry still needs its falling edge.
            ST_PAUSE: begin
                c.ld_led = 1'b1;
                if (bus.Continue) state_nxt = ST_PAUSE2;
            end
            ST_PAUSE2: begin
                c.ld_led = 1'b1;
                if (!bus.Continue) state_nxt = ST_FETCH1;
            end
            default: state_nxt = ST_HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_isdu_ctrl.sv
// tb_lc3_isdu_ctrl: self-checking bench for lc3_isdu_ctrl with a per-instruction trace model.
module tb_lc3_isdu_ctrl;
    import lc3_isdu_ctrl_pkg::*;

    localparam int MEM_WAIT = 3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    lc3_isdu_ctrl_if bus();

    lc3_isdu_ctrl #(.MEM_WAIT(MEM_WAIT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_fail = 0;
    ctrl_t exp_q[$];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic ctrl_t fetch_word();
        ctrl_t c = '0;
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.pcmux   = PCMUX_INC;
        c.ld_pc   = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t led_word();
        ctrl_t c = '0;
        c.ld_led = 1'b1;
        return c;
    endfunction

    // Expected control word for every cycle of one instruction, starting at its FETCH1.
    function automatic void model(input logic [15:0] ir, input logic ben);
        ctrl_t c;
        exp_q.delete();
        exp_q.push_back(fetch_word());
        for (int i = 0; i < MEM_WAIT; i++) begin
            c = '0; c.mem_oe = 1'b1; c.mio_en = 1'b1; c.ld_mdr = (i == MEM_WAIT - 1);
            exp_q.push_back(c);
        end
        c = '0; c.gate_mdr = 1'b1; c.ld_ir = 1'b1; exp_q.push_back(c);
        c = '0; c.ld_ben = 1'b1; exp_q.push_back(c);
        case (ir[15:12])
            4'h0: begin
                exp_q.push_back('0);
                if (ben) begin
                    c = '0; c.addr2mux = ADDR2_OFF9; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
                    exp_q.push_back(c);
                end
            end
            4'h1, 4'h5, 4'h9: begin
                c = '0;
                c.aluk = ir[15:12] == 4'h1 ? 2'b00 : ir[15:12] == 4'h5 ? 2'b01 : 2'b10;
                c.sr1mux = 1'b1; c.sr2mux = ir[5];
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                exp_q.push_back(c);
            end
            4'h6, 4'h7: begin
                c = '0; c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = ADDR2_OFF6;
                c.gate_marmux = 1'b1; c.ld_mar = 1'b1;
                exp_q.push_back(c);
                if (ir[15:12] == 4'h6) begin
                    for (int i = 0; i < MEM_WAIT; i++) begin
                        c = '0; c.mem_oe = 1'b1; c.mio_en = 1'b1; c.ld_mdr = (i == MEM_WAIT - 1);
                        exp_q.push_back(c);
                    end
                    c = '0; c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                    exp_q.push_back(c);
                end else begin
                    c = '0; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
                    exp_q.push_back(c);
                    for (int i = 0; i < MEM_WAIT; i++) begin
                        c = '0; c.mem_we = 1'b1;
                        exp_q.push_back(c);
                    end
                end
            end
            4'hC: begin
                c = '0; c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = ADDR2_ZERO;
                c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
                exp_q.push_back(c);
            end
            4'h4: begin
                c = '0; c.gate_pc = 1'b1; c.drmux = 1'b1; c.ld_reg = 1'b1;
                exp_q.push_back(c);
                c = '0; c.pcmux = PCMUX_ADDER; c.ld_pc = 1'b1;
                if (ir[11]) c.addr2mux = ADDR2_OFF11;
                else begin c.addr1mux = 1'b1; c.sr1mux = 1'b1; c.addr2mux = ADDR2_ZERO; end
                exp_q.push_back(c);
            end
            4'hD: exp_q.push_back(led_word());
            default: ;
        endcase
    endfunction

    // Runs one instruction from a FETCH1 sample point; ends at the next FETCH1
    // (or in PAUSE for opcode 1101).
    task automatic run_instr(input logic [15:0] ir, input logic ben, input string tag);
        bus.IR = ir;
        bus.BEN = ben;
        model(ir, ben);
        foreach (exp_q[i]) begin
            if (i > 0) tick();
            n_checks++;
            if (bus.Ctrl !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cycle %0d ctrl: got %h expected %h", tag, i, bus.Ctrl, exp_q[i]);
            end
            n_checks++;
            if ($countones({bus.Ctrl.gate_pc, bus.Ctrl.gate_mdr, bus.Ctrl.gate_alu, bus.Ctrl.gate_marmux}) > 1
                || (bus.Ctrl.ld_cc && bus.Ctrl.ld_ben) || (bus.Ctrl.mem_oe && bus.Ctrl.mem_we)) begin
                n_fail++;
                $display("FAIL %s cycle %0d exclusivity: ctrl %h", tag, i, bus.Ctrl);
            end
        end
        if (ir[15:12] != 4'hD) begin
            tick();
            n_checks++;
            if (bus.State_Dbg !== 5'(ST_FETCH1) || bus.Ctrl !== fetch_word()) begin
                n_fail++;
                $display("FAIL %s return: state %0d ctrl %h, expected state %0d ctrl %h",
                         tag, bus.State_Dbg, bus.Ctrl, 5'(ST_FETCH1), fetch_word());
            end
        end
    endtask

    task automatic test_reset();
        bus.Run = 1'b0; bus.Continue = 1'b0; bus.IR = '0; bus.BEN = 1'b0;
        Reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.State_Dbg !== 5'(ST_HALTED) || bus.Ctrl !== '0) begin
            n_fail++;
            $display("FAIL reset: state %0d ctrl %h, expected state %0d ctrl 0", bus.State_Dbg, bus.Ctrl, 5'(ST_HALTED));
        end
        Reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.State_Dbg !== 5'(ST_HALTED) || bus.Ctrl !== '0) begin
            n_fail++;
            $display("FAIL halted_idle: state %0d ctrl %h, expected HALTED ctrl 0", bus.State_Dbg, bus.Ctrl);
        end
        bus.Run = 1'b1;
        tick();
        bus.Run = 1'b0;
        n_checks++;
        if (bus.State_Dbg !== 5'(ST_FETCH1) || bus.Ctrl !== fetch_word()) begin
            n_fail++;
            $display("FAIL run_start: state %0d ctrl %h, expected FETCH1 ctrl %h", bus.State_Dbg, bus.Ctrl, fetch_word());
        end
    endtask

    task automatic test_alu();
        run_instr(16'h1261, 1'b0, "add");
        run_instr(16'h5262, 1'b1, "and_reg");
        run_instr(16'h927F, 1'b0, "not");
    endtask

    task automatic test_branch();
        run_instr(16'h0E05, 1'b1, "br_taken");
        run_instr(16'h0E05, 1'b0, "br_not_taken");
    endtask

    task automatic test_mem();
        run_instr(16'h6042, 1'b0, "ldr");
        run_instr(16'h7042, 1'b1, "str");
    endtask

    task automatic test_jump();
        run_instr(16'hC1C0, 1'b0, "jmp");
        run_instr(16'h4801, 1'b0, "jsr");
        run_instr(16'h4080, 1'b1, "jsrr");
    endtask

    task automatic test_pause(input logic cont0, input string tag);
        bus.Continue = cont0;
        run_instr(16'hD000, 1'b0, tag);
        repeat (3) begin
            tick();
            n_checks++;
            if (bus.Ctrl !== led_word()) begin
                n_fail++;
                $display("FAIL %s hold: ctrl %h expected %h", tag, bus.Ctrl, led_word());
            end
        end
        bus.Continue = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if (bus.Ctrl !== led_word()) begin
                n_fail++;
                $display("FAIL %s continue_high: ctrl %h expected %h", tag, bus.Ctrl, led_word());
            end
        end
        bus.Continue = 1'b0;
        tick();
        n_checks++;
        if (bus.State_Dbg !== 5'(ST_FETCH1) || bus.Ctrl !== fetch_word()) begin
            n_fail++;
            $display("FAIL %s release: state %0d ctrl %h, expected FETCH1", tag, bus.State_Dbg, bus.Ctrl);
        end
    endtask

    task automatic test_random();
        logic [15:0] ir;
        for (int k = 0; k < 40; k++) begin
            ir = 16'($urandom);
            if (ir[15:12] == 4'hD) ir[15:12] = 4'h0;
            bus.Run = 1'($urandom);
            run_instr(ir, 1'($urandom), $sformatf("rand%0d_%h", k, ir));
        end
        bus.Run = 1'b0;
    endtask

    task automatic test_reset_mid_str();
        bus.IR = 16'h7042;
        repeat (5 + MEM_WAIT + 1) tick();
        n_checks++;
        if (bus.Ctrl.mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL str_abort setup: mem_we %b expected 1", bus.Ctrl.mem_we);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_checks++;
        if (bus.State_Dbg !== 5'(ST_HALTED) || bus.Ctrl !== '0) begin
            n_fail++;
            $display("FAIL str_abort reset: state %0d ctrl %h, expected HALTED ctrl 0", bus.State_Dbg, bus.Ctrl);
        end
        repeat (4) begin
            tick();
            n_checks++;
            if (bus.Ctrl.mem_we !== 1'b0 || bus.State_Dbg !== 5'(ST_HALTED)) begin
                n_fail++;
                $display("FAIL str_abort after: mem_we %b state %0d, expected 0 and HALTED", bus.Ctrl.mem_we, bus.State_Dbg);
            end
        end
        bus.Run = 1'b1;
        tick();
        bus.Run = 1'b0;
        n_checks++;
        if (bus.State_Dbg !== 5'(ST_FETCH1)) begin
            n_fail++;
            $display("FAIL str_abort restart: state %0d expected FETCH1", bus.State_Dbg);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem();
        test_jump();
        test_pause(1'b1, "pause_cont_high");
        test_pause(1'b0, "pause_cont_low");
        test_random();
        test_reset_mid_str();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
